tpu_host_arbiter: RTL and testbench
===================================

TPU_HOST_ARBITER -- requirements
Module: tpu_host_arbiter

Interface
REQ-001 Parameters (name, default, meaning): FIFO_DEPTH, 4, per-requester command FIFO entries (power of 2, >=2); TIMEOUT_CYCLES, 1000000, watchdog limit.
REQ-002 Port clk  in  1  system clock (100 MHz); one clock domain only.
REQ-003 Port rst  in  1  reset, synchronous, active-high.
REQ-004 Port reqN_valid  in  1  (N=0 SPI, N=1 buttons) command push strobe, one cycle per command.
REQ-005 Port reqN_cmd  in  1  0=WRITE, 1=START.
REQ-006 Port reqN_addr  in  8  write address; ignored for START.
REQ-007 Port reqN_data  in  8  write data; ignored for START.
REQ-008 Port reqN_full  out  1  FIFO N full.
REQ-009 Port reqN_done  out  1  one-cycle pulse: START issued by N completed.
REQ-010 Port tpu_addr, tpu_data_out  out  8 each  registered write address and data.
REQ-011 Port tpu_data_valid, tpu_write_enable, tpu_start  out  1 each  registered one-cycle strobes.
REQ-012 Port tpu_busy, tpu_done  in  1 each  TPU status.
REQ-013 Port owner  out  1  requester of the current or most recent START.
REQ-014 Port arb_state  out  2  encoded FSM state.
REQ-015 Port overflow  out  2  sticky per-requester drop flags.
REQ-016 Port timeout_err  out  1  sticky watchdog flag (constant 0 when the watchdog is compiled out).

Function
REQ-017 Each requester SHALL own a FIFO of {cmd, addr, data}; a push while full SHALL be dropped and set overflow[N], even if a pop occurs in the same cycle.
REQ-018 FSM states SHALL be IDLE=0, WAIT_BUSY=1, WAIT_DONE=2.
REQ-019 Pops SHALL occur only in IDLE, at most one per cycle.
REQ-020 Selection SHALL be round-robin: with both FIFOs non-empty, grant the requester not granted last; with one non-empty, grant it; last_grant resets to 1 so requester 0 wins first.
REQ-021 Popped WRITE: in the next cycle, drive tpu_addr/tpu_data_out and assert tpu_data_valid and tpu_write_enable for exactly one cycle; stay in IDLE, so back-to-back writes run at one per cycle.
REQ-022 Popped START: in the next cycle, pulse tpu_start, latch owner and enter WAIT_BUSY.
REQ-023 WAIT_BUSY: tpu_done=1 -> pulse reqN_done for owner, go to IDLE; else tpu_busy=1 -> WAIT_DONE; else hold.
REQ-024 WAIT_DONE: tpu_done=1 -> pulse reqN_done for owner, go to IDLE.
REQ-025 No pops in WAIT_BUSY or WAIT_DONE; both FIFOs continue accepting pushes.
REQ-026 A START popped while tpu_busy=1 SHALL still pulse tpu_start, then follow REQ-023 (the TPU ignores it while busy; completion comes from tpu_done).
REQ-027 Latency: a push into an empty FIFO at edge k, in IDLE and winning arbitration, SHALL be popped at edge k+1, with strobes high during the cycle after edge k+1.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL use an extra pointer bit.
REQ-029 reqN_full SHALL be combinational from FIFO state.
REQ-030 tpu_addr and tpu_data_out SHALL hold their last value when not strobed.

Reset
REQ-031 On rst=1 at a clock edge: FIFOs flushed, state=IDLE, last_grant=1, owner=0, all strobes/done=0, tpu_addr=tpu_data_out=0, overflow=0, timeout_err=0.
REQ-032 Reset mid-run SHALL abandon WAIT_* without a done pulse; pushes during reset SHALL be ignored.

Configuration
REQ-033 Macro TPU_ARB_TIMEOUT_EN defined: a counter cleared on entry to WAIT_BUSY increments in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT_CYCLES, set timeout_err, go to IDLE, and emit no done pulse.
REQ-034 Macro undefined: no counter; WAIT states wait indefinitely; timeout_err tied to 0.

Verification
REQ-035 Req0 pushes WRITE(0x05,0xAA) at edge k -> tpu_write_enable=tpu_data_valid=1 for one cycle after edge k+1, with tpu_addr=0x05 and tpu_data_out=0xAA.
REQ-036 Both FIFOs hold 3 WRITEs each -> issue order r0,r1,r0,r1,r0,r1 on 6 consecutive cycles.
REQ-037 Req1 START, tpu_busy high for 10 cycles, then tpu_done -> one tpu_start pulse, arb_state 1->2->0, req1_done one pulse, owner=1; a req0 WRITE queued meanwhile issues only after return to IDLE.
REQ-038 During WAIT_DONE, push 5 WRITEs to req0 (depth 4) -> req0_full=1 after 4, 5th dropped, overflow=2'b01.
REQ-039 TIMEOUT_CYCLES=50, macro defined, START with no busy/done -> after 50 cycles timeout_err=1, state=IDLE, no done pulse; macro undefined -> state stays 1.
REQ-040 Assert rst in WAIT_DONE with 2 queued entries -> next cycle all outputs at reset values, FIFOs empty, no done pulse.

Source files
------------

// File: rtl/tpu_host_arbiter_if.sv
// Signal bundle between the two command hosts (SPI = 0, buttons = 1), the TPU write/start
// port and the arbiter. The arbiter connects through the slave modport.
interface tpu_host_arbiter_if;
  logic       req0_valid;
  logic       req0_cmd;
  logic [7:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_full;
  logic       req0_done;

  logic       req1_valid;
  logic       req1_cmd;
  logic [7:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_full;
  logic       req1_done;

  logic [7:0] tpu_addr;
  logic [7:0] tpu_data_out;
  logic       tpu_data_valid;
  logic       tpu_write_enable;
  logic       tpu_start;
  logic       tpu_busy;
  logic       tpu_done;

  logic       owner;
  logic [1:0] arb_state;
  logic [1:0] overflow;
  logic       timeout_err;

  modport master (
    output req0_valid, req0_cmd, req0_addr, req0_data,
    output req1_valid, req1_cmd, req1_addr, req1_data,
    output tpu_busy, tpu_done,
    input  req0_full, req0_done, req1_full, req1_done,
    input  tpu_addr, tpu_data_out, tpu_data_valid, tpu_write_enable, tpu_start,
    input  owner, arb_state, overflow, timeout_err
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_addr, req0_data,
    input  req1_valid, req1_cmd, req1_addr, req1_data,
    input  tpu_busy, tpu_done,
    output req0_full, req0_done, req1_full, req1_done,
    output tpu_addr, tpu_data_out, tpu_data_valid, tpu_write_enable, tpu_start,
    output owner, arb_state, overflow, timeout_err
  );
endinterface

// File: rtl/tpu_host_arbiter.sv
// Two-host round-robin command arbiter in front of the TPU: per-host FIFOs, WRITE/START issue FSM.
// Optional watchdog on the WAIT states is compiled in with `define TPU_ARB_TIMEOUT_EN.
module tpu_host_arbiter #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic               clk,
  input logic               rst,
  tpu_host_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BUSY = 2'd1, WAIT_DONE = 2'd2} state_e;
  typedef struct packed {
    logic       start;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t        push_entry [2];
  cmd_t        fifo_mem_q [2][FIFO_DEPTH];
  logic [AW:0] wr_ptr_q [2], wr_ptr_d [2], rd_ptr_q [2], rd_ptr_d [2];
  logic [1:0]  push_valid, push_ok, pop, full, empty;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d, owner_q, owner_d;
  logic [7:0] tpu_addr_q, tpu_addr_d, tpu_data_q, tpu_data_d;
  logic       data_valid_q, data_valid_d, write_en_q, write_en_d, start_q, start_d;
  logic [1:0] done_q, done_d, overflow_q, overflow_d;
  logic       grant, grant_valid;
  cmd_t       head;

`ifdef TPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  always_comb begin : p_param_check
    assert (FIFO_DEPTH >= 2 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0 && TIMEOUT_CYCLES >= 1);
  end

  assign push_valid    = {bus.req1_valid, bus.req0_valid};
  assign push_entry[0] = cmd_t'({bus.req0_cmd, bus.req0_addr, bus.req0_data});
  assign push_entry[1] = cmd_t'({bus.req1_cmd, bus.req1_addr, bus.req1_data});

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      empty[n] = (wr_ptr_q[n] == rd_ptr_q[n]);
      full[n]  = (wr_ptr_q[n][AW] != rd_ptr_q[n][AW]) &&
                 (wr_ptr_q[n][AW-1:0] == rd_ptr_q[n][AW-1:0]);
    end
  end

  // Fullness is judged before this edge's pop, so a push into a full FIFO is dropped.
  assign push_ok     = push_valid & ~full;
  assign grant       = (empty[0] | empty[1]) ? empty[0] : ~last_grant_q;
  assign grant_valid = (state_q == IDLE) && (empty != 2'b11);
  assign head        = fifo_mem_q[grant][rd_ptr_q[grant][AW-1:0]];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      wr_ptr_d[n] = wr_ptr_q[n] + (AW+1)'(push_ok[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + (AW+1)'(pop[n]);
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    tpu_addr_d   = tpu_addr_q;
    tpu_data_d   = tpu_data_q;
    data_valid_d = 1'b0;
    write_en_d   = 1'b0;
    start_d      = 1'b0;
    done_d       = 2'b00;
    pop          = 2'b00;
    overflow_d   = overflow_q | (push_valid & full);

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          pop[grant]   = 1'b1;
          last_grant_d = grant;
          if (head.start) begin
            start_d = 1'b1;
            owner_d = grant;
            state_d = WAIT_BUSY;
          end else begin
            tpu_addr_d   = head.addr;
            tpu_data_d   = head.data;
            data_valid_d = 1'b1;
            write_en_d   = 1'b1;
          end
        end
      end
      WAIT_BUSY: begin
        if (bus.tpu_done) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else if (bus.tpu_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tpu_done) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef TPU_ARB_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = '0;
    if (state_q != IDLE) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
      if (!bus.tpu_done && wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d       = IDLE;
        timeout_err_d = 1'b1;
      end
    end
`endif
  end

  // NOTE: the storage array is not reset; the pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push_ok[n]) fifo_mem_q[n][wr_ptr_q[n][AW-1:0]] <= push_entry[n];
    end
  end

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
      end
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      tpu_addr_q   <= '0;
      tpu_data_q   <= '0;
      data_valid_q <= 1'b0;
      write_en_q   <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 2'b00;
      overflow_q   <= 2'b00;
`ifdef TPU_ARB_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
      end
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      tpu_addr_q   <= tpu_addr_d;
      tpu_data_q   <= tpu_data_d;
      data_valid_q <= data_valid_d;
      write_en_q   <= write_en_d;
      start_q      <= start_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
`ifdef TPU_ARB_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.req0_full        = full[0];
  assign bus.req1_full        = full[1];
  assign bus.req0_done        = done_q[0];
  assign bus.req1_done        = done_q[1];
  assign bus.tpu_addr         = tpu_addr_q;
  assign bus.tpu_data_out     = tpu_data_q;
  assign bus.tpu_data_valid   = data_valid_q;
  assign bus.tpu_write_enable = write_en_q;
  assign bus.tpu_start        = start_q;
  assign bus.owner            = owner_q;
  assign bus.arb_state        = state_q;
  assign bus.overflow         = overflow_q;
`ifdef TPU_ARB_TIMEOUT_EN
  assign bus.timeout_err      = timeout_err_q;
`else
  assign bus.timeout_err      = 1'b0;
`endif
endmodule

// File: tb/tb_tpu_host_arbiter.sv
// Self-checking bench for tpu_host_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_tpu_host_arbiter;
  localparam int DEPTH = 4;
  localparam int TB_TO = 50;
`ifdef TPU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_host_arbiter_if bus ();
  tpu_host_arbiter #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TB_TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: each host is a queue of {start, addr, data}.
  logic [16:0] mq0[$];
  logic [16:0] mq1[$];
  int          m_state = 0;
  int          m_cnt   = 0;
  logic        m_last = 1'b1, m_owner = 1'b0, m_dv = 1'b0, m_we = 1'b0, m_start = 1'b0, m_terr = 1'b0;
  logic [7:0]  m_addr = '0, m_data = '0;
  logic [1:0]  m_done = '0, m_ovf = '0;

  always @(posedge clk) begin
    bit          f0, f1, g;
    logic [16:0] e;
    if (rst) begin
      mq0.delete();
      mq1.delete();
      m_state = 0; m_cnt = 0; m_last = 1'b1; m_owner = 1'b0;
      m_dv = 1'b0; m_we = 1'b0; m_start = 1'b0; m_terr = 1'b0;
      m_addr = '0; m_data = '0; m_done = '0; m_ovf = '0;
    end else begin
      f0 = (mq0.size() >= DEPTH);
      f1 = (mq1.size() >= DEPTH);
      m_dv = 1'b0; m_we = 1'b0; m_start = 1'b0; m_done = 2'b00;
      if (m_state == 0) begin
        if (mq0.size() > 0 || mq1.size() > 0) begin
          if (mq0.size() > 0 && mq1.size() > 0) g = ~m_last;
          else g = (mq0.size() == 0);
          e = g ? mq1.pop_front() : mq0.pop_front();
          m_last = g;
          if (e[16]) begin
            m_start = 1'b1; m_owner = g; m_state = 1; m_cnt = 0;
          end else begin
            m_we = 1'b1; m_dv = 1'b1; m_addr = e[15:8]; m_data = e[7:0];
          end
        end
      end else begin
        m_cnt++;
        if (bus.tpu_done) begin
          m_done[m_owner] = 1'b1; m_state = 0;
        end else if (TO_EN && m_cnt >= TB_TO) begin
          m_terr = 1'b1; m_state = 0;
        end else if (m_state == 1 && bus.tpu_busy) begin
          m_state = 2;
        end
      end
      if (bus.req0_valid) begin
        if (f0) m_ovf[0] = 1'b1;
        else mq0.push_back({bus.req0_cmd, bus.req0_addr, bus.req0_data});
      end
      if (bus.req1_valid) begin
        if (f1) m_ovf[1] = 1'b1;
        else mq1.push_back({bus.req1_cmd, bus.req1_addr, bus.req1_data});
      end
    end
  end

  // Single compare process, sampling away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_arb_state", bus.arb_state, m_state);
      check("m_tpu_addr", bus.tpu_addr, m_addr);
      check("m_tpu_data", bus.tpu_data_out, m_data);
      check("m_data_valid", bus.tpu_data_valid, m_dv);
      check("m_write_en", bus.tpu_write_enable, m_we);
      check("m_tpu_start", bus.tpu_start, m_start);
      check("m_owner", bus.owner, m_owner);
      check("m_done", {bus.req1_done, bus.req0_done}, m_done);
      check("m_overflow", bus.overflow, m_ovf);
      check("m_timeout_err", bus.timeout_err, m_terr);
      check("m_req0_full", bus.req0_full, mq0.size() >= DEPTH);
      check("m_req1_full", bus.req1_full, mq1.size() >= DEPTH);
    end
  end

  task automatic drive_push(input int n, input logic cmd, input logic [7:0] a, input logic [7:0] d);
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_cmd = cmd; bus.req0_addr = a; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_cmd = cmd; bus.req1_addr = a; bus.req1_data = d;
    end
  endtask

  task automatic clear_push();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] exp_order [6];
    bit         seen_done;
    int         rate;
    exp_order = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};

    rst = 1'b1;
    clear_push();
    bus.req0_cmd = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_cmd = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.tpu_busy = 1'b0; bus.tpu_done = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_state", bus.arb_state, 0);
    check("reset_owner", bus.owner, 0);
    check("reset_addr", bus.tpu_addr, 0);
    check("reset_strobes", {bus.tpu_start, bus.tpu_write_enable, bus.tpu_data_valid}, 0);
    check("reset_full", {bus.req1_full, bus.req0_full}, 0);

    // Single WRITE: strobes visible in the cycle after the second edge.
    rst = 1'b0;
    drive_push(0, 1'b0, 8'h05, 8'hAA);
    @(negedge clk);
    clear_push();
    check("w1_no_early_we", bus.tpu_write_enable, 0);
    @(negedge clk);
    check("w1_we", bus.tpu_write_enable, 1);
    check("w1_dv", bus.tpu_data_valid, 1);
    check("w1_addr", bus.tpu_addr, 8'h05);
    check("w1_data", bus.tpu_data_out, 8'hAA);
    @(negedge clk);
    check("w1_we_one_cycle", bus.tpu_write_enable, 0);
    check("w1_addr_hold", bus.tpu_addr, 8'h05);

    // Round-robin: park in WAIT_BUSY behind a req1 START, fill both FIFOs, release.
    drive_push(1, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    clear_push();
    @(negedge clk);
    check("rr_state_wait", bus.arb_state, 1);
    check("rr_start", bus.tpu_start, 1);
    for (int i = 0; i < 3; i++) begin
      drive_push(0, 1'b0, 8'h10 + 8'(i), 8'h30 + 8'(i));
      drive_push(1, 1'b0, 8'h20 + 8'(i), 8'h40 + 8'(i));
      @(negedge clk);
    end
    clear_push();
    check("rr_hold_wait", bus.arb_state, 1);
    bus.tpu_done = 1'b1;
    @(negedge clk);
    bus.tpu_done = 1'b0;
    check("rr_req1_done", bus.req1_done, 1);
    check("rr_back_idle", bus.arb_state, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_we", bus.tpu_write_enable, 1);
      check("rr_order", bus.tpu_addr, exp_order[i]);
    end
    @(negedge clk);
    check("rr_drained", bus.tpu_write_enable, 0);

    // req1 START through busy for 10 cycles; a req0 WRITE waits for IDLE.
    drive_push(1, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    clear_push();
    @(negedge clk);
    check("st_state1", bus.arb_state, 1);
    check("st_owner", bus.owner, 1);
    bus.tpu_busy = 1'b1;
    drive_push(0, 1'b0, 8'h77, 8'h88);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clear_push();
      check("st_state2", bus.arb_state, 2);
      check("st_no_write", bus.tpu_write_enable, 0);
      check("st_one_start", bus.tpu_start, 0);
    end
    bus.tpu_busy = 1'b0;
    bus.tpu_done = 1'b1;
    @(negedge clk);
    bus.tpu_done = 1'b0;
    check("st_state0", bus.arb_state, 0);
    check("st_done1", {bus.req1_done, bus.req0_done}, 2'b10);
    check("st_owner_kept", bus.owner, 1);
    @(negedge clk);
    check("st_done_pulse", bus.req1_done, 0);
    check("st_write_after", bus.tpu_write_enable, 1);
    check("st_write_addr", bus.tpu_addr, 8'h77);

    // Overflow: 5 pushes to req0 during WAIT_DONE.
    drive_push(0, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    clear_push();
    bus.tpu_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ov_state2", bus.arb_state, 2);
    for (int i = 0; i < 5; i++) begin
      drive_push(0, 1'b0, 8'h50 + 8'(i), 8'h60 + 8'(i));
      @(negedge clk);
      check("ov_full", bus.req0_full, (i >= 3) ? 1 : 0);
    end
    clear_push();
    check("ov_flag", bus.overflow, 2'b01);
    bus.tpu_busy = 1'b0;
    bus.tpu_done = 1'b1;
    @(negedge clk);
    bus.tpu_done = 1'b0;
    check("ov_done0", bus.req0_done, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ov_drain", bus.tpu_addr, 8'h50 + 8'(i));
    end
    check("ov_sticky", bus.overflow, 2'b01);

    // Reset in WAIT_DONE with two queued entries.
    drive_push(1, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    clear_push();
    bus.tpu_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    drive_push(0, 1'b0, 8'h91, 8'h01);
    @(negedge clk);
    drive_push(0, 1'b0, 8'h92, 8'h02);
    @(negedge clk);
    clear_push();
    check("rs_pre_state", bus.arb_state, 2);
    rst = 1'b1;
    bus.tpu_done = 1'b1;
    @(negedge clk);
    check("rs_state", bus.arb_state, 0);
    check("rs_owner", bus.owner, 0);
    check("rs_overflow", bus.overflow, 0);
    check("rs_done", {bus.req1_done, bus.req0_done}, 0);
    check("rs_addr_data", {bus.tpu_addr, bus.tpu_data_out}, 0);
    check("rs_strobes", {bus.tpu_start, bus.tpu_write_enable, bus.tpu_data_valid}, 0);
    rst = 1'b0;
    bus.tpu_done = 1'b0;
    bus.tpu_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rs_fifo_empty", {bus.tpu_write_enable, bus.req1_done, bus.req0_done}, 0);
    end

    // Watchdog: START with the TPU silent.
    drive_push(0, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    clear_push();
    seen_done = 1'b0;
    for (int i = 0; i < TB_TO + 5; i++) begin
      @(negedge clk);
      seen_done |= bus.req0_done | bus.req1_done;
    end
    check("to_no_done", seen_done, 0);
`ifdef TPU_ARB_TIMEOUT_EN
    check("to_state", bus.arb_state, 0);
    check("to_err", bus.timeout_err, 1);
`else
    check("to_state", bus.arb_state, 1);
    check("to_err", bus.timeout_err, 0);
`endif
    bus.tpu_done = 1'b1;
    @(negedge clk);
    bus.tpu_done = 1'b0;
    check("to_idle", bus.arb_state, 0);

    // Randomized traffic with occasional resets; the compare process checks every cycle.
    rst = 1'b1;
    @(negedge clk);
    rate = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rate = $urandom_range(10, 80);
      rst = ($urandom_range(0, 299) == 0);
      bus.req0_valid = ($urandom_range(0, 99) < rate);
      bus.req0_cmd   = ($urandom_range(0, 7) == 0);
      bus.req0_addr  = 8'($urandom);
      bus.req0_data  = 8'($urandom);
      bus.req1_valid = ($urandom_range(0, 99) < rate);
      bus.req1_cmd   = ($urandom_range(0, 7) == 0);
      bus.req1_addr  = 8'($urandom);
      bus.req1_data  = 8'($urandom);
      bus.tpu_busy   = ($urandom_range(0, 2) == 0);
      bus.tpu_done   = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    clear_push();
    rst = 1'b0;
    bus.tpu_busy = 1'b0;
    bus.tpu_done = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
